// File: rtl/alu_issue_queue_if.sv
// Request and result channels of the ALU issue queue.
// The queue sits on the slave side; the producer/consumer sits on master.
interface alu_issue_queue_if;
  logic       in_valid;
  logic       in_ready;
  logic [1:0] in_op;
  logic [3:0] in_a;
  logic [3:0] in_b;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_res;
  logic [1:0] out_op;
  logic       out_zero;
  logic       out_ov;
  logic       out_cout;

  modport master (
    output in_valid, in_op, in_a, in_b, out_ready,
    input  in_ready, out_valid, out_res, out_op, out_zero, out_ov, out_cout
  );

  modport slave (
    input  in_valid, in_op, in_a, in_b, out_ready,
    output in_ready, out_valid, out_res, out_op, out_zero, out_ov, out_cout
  );
endinterface

// File: rtl/alu_issue_queue.sv
// Issue stage for the 4-bit ALU: request FIFO -> operand registers -> ALU
// (combinational, external) -> result register with valid/ready output.
module alu_issue_queue #(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  alu_issue_queue_if.slave       bus,
  output logic                   Ctrl1,
  output logic                   Ctrl0,
  output logic [3:0]             A,
  output logic [3:0]             B,
  input  logic [3:0]             ResH,
  input  logic [3:0]             ResL,
  input  logic                   Zero,
  input  logic                   Overflow,
  input  logic                   Cout,
  input  logic                   clr_sticky,
  output logic                   sticky_ov,
  output logic [$clog2(DEPTH):0] fifo_count,
  output logic [7:0]             ops_done
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [1:0]    mem_op [DEPTH];
  logic [3:0]    mem_a  [DEPTH];
  logic [3:0]    mem_b  [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          opv;
  logic          stall;
  logic          push;
  logic          pop;
  logic          capture;

  // in_ready depends only on the registered count, so a pop never frees a slot
  // for a push in the same cycle.
  assign stall        = bus.out_valid & ~bus.out_ready;
  assign bus.in_ready = (fifo_count < CW'(DEPTH));
  assign push         = bus.in_valid & bus.in_ready;
  assign pop          = ~stall & (fifo_count != '0);
  assign capture      = ~stall & opv;

  always_ff @(posedge clk) begin
    if (push) begin
      mem_op[wr_ptr] <= bus.in_op;
      mem_a[wr_ptr]  <= bus.in_a;
      mem_b[wr_ptr]  <= bus.in_b;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      fifo_count <= fifo_count + CW'(push) - CW'(pop);
    end
  end

  // Operand registers keep their last value when the stage goes empty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      opv   <= 1'b0;
      Ctrl1 <= 1'b0;
      Ctrl0 <= 1'b0;
      A     <= '0;
      B     <= '0;
    end else if (!stall) begin
      opv <= pop;
      if (pop) begin
        {Ctrl1, Ctrl0} <= mem_op[rd_ptr];
        A              <= mem_a[rd_ptr];
        B              <= mem_b[rd_ptr];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.out_valid <= 1'b0;
      bus.out_res   <= '0;
      bus.out_op    <= '0;
      bus.out_zero  <= 1'b0;
      bus.out_ov    <= 1'b0;
      bus.out_cout  <= 1'b0;
    end else if (!stall) begin
      bus.out_valid <= opv;
      if (opv) begin
        bus.out_res  <= {ResH, ResL};
        bus.out_op   <= {Ctrl1, Ctrl0};
        bus.out_zero <= Zero;
        bus.out_ov   <= Overflow;
        bus.out_cout <= Cout;
      end
    end
  end

  // Set wins over clear so a coincident overflow is never lost.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sticky_ov <= 1'b0;
      ops_done  <= '0;
    end else begin
      if (capture && Overflow) sticky_ov <= 1'b1;
      else if (clr_sticky)     sticky_ov <= 1'b0;
      if (bus.out_valid && bus.out_ready) ops_done <= ops_done + 8'd1;
    end
  end
endmodule

// File: tb/tb_alu_issue_queue.sv
// Directed bench for alu_issue_queue with a behavioural 4-bit ALU attached.
module tb_alu_issue_queue;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       Ctrl1, Ctrl0;
  logic [3:0] A, B, ResH, ResL;
  logic       Zero, Overflow, Cout;
  logic       clr_sticky;
  logic       sticky_ov;
  logic [2:0] fifo_count;
  logic [7:0] ops_done;

  int n_checks = 0;
  int n_fail   = 0;
  logic [12:0] expq[$];

  logic [1:0] t_op [8] = '{2'b00, 2'b01, 2'b10, 2'b11, 2'b00, 2'b01, 2'b10, 2'b00};
  logic [3:0] t_a  [8] = '{4'h3, 4'h5, 4'he, 4'hc, 4'h7, 4'h8, 4'h7, 4'hf};
  logic [3:0] t_b  [8] = '{4'h4, 4'h2, 4'h3, 4'ha, 4'h6, 4'h1, 4'h7, 4'h1};

  alu_issue_queue_if bus ();

  alu_issue_queue #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus),
    .Ctrl1(Ctrl1), .Ctrl0(Ctrl0), .A(A), .B(B),
    .ResH(ResH), .ResL(ResL), .Zero(Zero), .Overflow(Overflow), .Cout(Cout),
    .clr_sticky(clr_sticky), .sticky_ov(sticky_ov),
    .fifo_count(fifo_count), .ops_done(ops_done)
  );

  always #5 clk = ~clk;

  // Behavioural ALU: 00 add, 01 sub, 10 signed multiply, 11 and.
  function automatic logic [10:0] alu_fn(input logic [1:0] op, input logic [3:0] a, input logic [3:0] b);
    logic [4:0] u;
    logic [3:0] r4;
    logic [7:0] r;
    logic signed [7:0] sa, sb;
    logic ov, c;
    u = '0; r4 = '0; r = '0; ov = 1'b0; c = 1'b0;
    sa = {{4{a[3]}}, a};
    sb = {{4{b[3]}}, b};
    case (op)
      2'b00: begin
        u  = {1'b0, a} + {1'b0, b};
        r4 = u[3:0];
        c  = u[4];
        ov = (a[3] == b[3]) && (r4[3] != a[3]);
        r  = {{4{ov ? ~r4[3] : r4[3]}}, r4};
      end
      2'b01: begin
        u  = {1'b0, a} - {1'b0, b};
        r4 = u[3:0];
        c  = ~u[4];
        ov = (a[3] != b[3]) && (r4[3] != a[3]);
        r  = {{4{ov ? ~r4[3] : r4[3]}}, r4};
      end
      2'b10: r = sa * sb;
      default: r = {4'b0000, a & b};
    endcase
    return {r, (r == 8'd0), ov, c};
  endfunction

  function automatic logic [12:0] expect_of(input logic [1:0] op, input logic [3:0] a, input logic [3:0] b);
    return {op, alu_fn(op, a, b)};
  endfunction

  always_comb {ResH, ResL, Zero, Overflow, Cout} = alu_fn({Ctrl1, Ctrl0}, A, B);

  logic [12:0] observed;
  assign observed = {bus.out_op, bus.out_res, bus.out_zero, bus.out_ov, bus.out_cout};

  task automatic do_reset();
    bus.in_valid = 1'b0; bus.in_op = '0; bus.in_a = '0; bus.in_b = '0;
    bus.out_ready = 1'b0; clr_sticky = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    expq.delete();
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++;
    if ({bus.out_valid, bus.in_ready} !== 2'b01) begin
      n_fail++; $display("[TB] FAIL reset_handshake: got valid/ready=%b expected 01", {bus.out_valid, bus.in_ready});
    end
    n_checks++;
    if ({Ctrl1, Ctrl0, A, B} !== 10'd0) begin
      n_fail++; $display("[TB] FAIL reset_operands: got %h expected 0", {Ctrl1, Ctrl0, A, B});
    end
    n_checks++;
    if (observed !== 13'd0) begin
      n_fail++; $display("[TB] FAIL reset_result: got %h expected 0", observed);
    end
    n_checks++;
    if ({fifo_count, sticky_ov, ops_done} !== 12'd0) begin
      n_fail++; $display("[TB] FAIL reset_status: got %h expected 0", {fifo_count, sticky_ov, ops_done});
    end
  endtask

  task automatic test_single();
    bus.out_ready = 1'b1;
    bus.in_valid = 1'b1; bus.in_op = 2'b00; bus.in_a = 4'b1101; bus.in_b = 4'b0111;
    @(negedge clk);
    bus.in_valid = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({Ctrl1, Ctrl0, A, B, bus.out_valid} !== {2'b00, 4'b1101, 4'b0111, 1'b0}) begin
      n_fail++; $display("[TB] FAIL single_operands: got %b expected 00_1101_0111_0", {Ctrl1, Ctrl0, A, B, bus.out_valid});
    end
    @(negedge clk);
    n_checks++;
    if ({bus.out_valid, bus.out_res, bus.out_zero, bus.out_ov, bus.out_cout} !== {1'b1, 8'h04, 3'b001}) begin
      n_fail++; $display("[TB] FAIL single_result: got %h expected %h",
                         {bus.out_valid, bus.out_res, bus.out_zero, bus.out_ov, bus.out_cout}, {1'b1, 8'h04, 3'b001});
    end
    @(negedge clk);
    n_checks++;
    if ({ops_done, bus.out_valid} !== {8'd1, 1'b0}) begin
      n_fail++; $display("[TB] FAIL single_ops_done: got %0d/%b expected 1/0", ops_done, bus.out_valid);
    end
  endtask

  int k;

  task automatic test_fill();
    do_reset();
    k = 0;
    for (int cyc = 0; cyc < 10; cyc++) begin
      bus.in_valid = 1'b1; bus.in_op = t_op[k]; bus.in_a = t_a[k]; bus.in_b = t_b[k];
      if (bus.in_ready) begin
        expq.push_back(expect_of(t_op[k], t_a[k], t_b[k]));
        k++;
      end
      @(negedge clk);
    end
    n_checks++;
    if (k !== 6) begin
      n_fail++; $display("[TB] FAIL fill_accepted: got %0d expected 6", k);
    end
    n_checks++;
    if ({bus.in_ready, fifo_count} !== {1'b0, 3'd4}) begin
      n_fail++; $display("[TB] FAIL fill_full: got ready=%b count=%0d expected 0/4", bus.in_ready, fifo_count);
    end
    n_checks++;
    if ({bus.out_valid, observed} !== {1'b1, expq[0]}) begin
      n_fail++; $display("[TB] FAIL fill_held_result: got %h expected %h", {bus.out_valid, observed}, {1'b1, expq[0]});
    end
  endtask

  task automatic test_drain();
    int got = 0, cyc = 0, first_cyc = -1, sixth_cyc = -1;
    logic [12:0] e;
    bus.out_ready = 1'b1;
    while (got < 8 && cyc < 40) begin
      if (k < 8) begin
        bus.in_valid = 1'b1; bus.in_op = t_op[k]; bus.in_a = t_a[k]; bus.in_b = t_b[k];
      end else bus.in_valid = 1'b0;
      if (bus.in_valid && bus.in_ready) begin
        expq.push_back(expect_of(t_op[k], t_a[k], t_b[k]));
        k++;
      end
      if (bus.out_valid) begin
        e = (expq.size() > 0) ? expq.pop_front() : 13'h1fff;
        n_checks++;
        if (observed !== e) begin
          n_fail++; $display("[TB] FAIL drain_result[%0d]: got %h expected %h", got, observed, e);
        end
        if (got == 0) first_cyc = cyc;
        if (got == 5) sixth_cyc = cyc;
        got++;
      end
      @(negedge clk);
      cyc++;
    end
    bus.in_valid = 1'b0;
    n_checks++;
    if (got !== 8) begin
      n_fail++; $display("[TB] FAIL drain_count: got %0d results expected 8", got);
    end
    n_checks++;
    if (sixth_cyc - first_cyc !== 5) begin
      n_fail++; $display("[TB] FAIL drain_back_to_back: got span %0d expected 5", sixth_cyc - first_cyc);
    end
    n_checks++;
    if (ops_done !== 8'd8) begin
      n_fail++; $display("[TB] FAIL drain_ops_done: got %0d expected 8", ops_done);
    end
  endtask

  task automatic test_sticky();
    bus.out_ready = 1'b1;
    clr_sticky = 1'b1;
    @(negedge clk);
    clr_sticky = 1'b0;
    n_checks++;
    if (sticky_ov !== 1'b0) begin
      n_fail++; $display("[TB] FAIL sticky_precleared: got %b expected 0", sticky_ov);
    end
    bus.in_valid = 1'b1; bus.in_op = 2'b00; bus.in_a = 4'b0111; bus.in_b = 4'b0001;
    @(negedge clk);
    bus.in_valid = 1'b0;
    @(negedge clk);
    clr_sticky = 1'b1;
    @(negedge clk);
    clr_sticky = 1'b0;
    n_checks++;
    if ({sticky_ov, bus.out_valid, bus.out_ov} !== 3'b111) begin
      n_fail++; $display("[TB] FAIL sticky_set_beats_clear: got %b expected 111", {sticky_ov, bus.out_valid, bus.out_ov});
    end
    @(negedge clk);
    n_checks++;
    if (sticky_ov !== 1'b1) begin
      n_fail++; $display("[TB] FAIL sticky_hold: got %b expected 1", sticky_ov);
    end
    clr_sticky = 1'b1;
    @(negedge clk);
    clr_sticky = 1'b0;
    n_checks++;
    if (sticky_ov !== 1'b0) begin
      n_fail++; $display("[TB] FAIL sticky_clear: got %b expected 0", sticky_ov);
    end
  endtask

  task automatic test_midstream_reset();
    logic saw_valid;
    bus.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus.in_valid = 1'b1; bus.in_op = t_op[i + 1]; bus.in_a = t_a[i + 1]; bus.in_b = t_b[i + 1];
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({bus.out_valid, A, B, fifo_count, ops_done} !== 20'd0) begin
      n_fail++; $display("[TB] FAIL midreset_clear: got valid=%b A=%h B=%h count=%0d done=%0d expected all 0",
                         bus.out_valid, A, B, fifo_count, ops_done);
    end
    @(negedge clk);
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    saw_valid = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (bus.out_valid) saw_valid = 1'b1;
    end
    n_checks++;
    if ({saw_valid, ops_done} !== 9'd0) begin
      n_fail++; $display("[TB] FAIL midreset_no_result: got valid_seen=%b done=%0d expected 0/0", saw_valid, ops_done);
    end
    expq.delete();
  endtask

  task automatic test_wrap();
    int sent = 0, got = 0, cyc = 0;
    logic [1:0] op;
    logic [3:0] a, b;
    logic [12:0] e;
    do_reset();
    while (got < 257 && cyc < 3000) begin
      op = 2'(sent);
      a  = 4'(sent * 3);
      b  = 4'(sent * 7 + 1);
      bus.in_valid = (sent < 257); bus.in_op = op; bus.in_a = a; bus.in_b = b;
      bus.out_ready = (cyc % 7 != 3);
      if (bus.in_valid && bus.in_ready) begin
        expq.push_back(expect_of(op, a, b));
        sent++;
      end
      if (bus.out_valid && bus.out_ready) begin
        e = (expq.size() > 0) ? expq.pop_front() : 13'h1fff;
        n_checks++;
        if (observed !== e) begin
          n_fail++; $display("[TB] FAIL wrap_result[%0d]: got %h expected %h", got, observed, e);
        end
        got++;
      end
      @(negedge clk);
      cyc++;
    end
    bus.in_valid = 1'b0;
    n_checks++;
    if (got !== 257) begin
      n_fail++; $display("[TB] FAIL wrap_count: got %0d results expected 257", got);
    end
    n_checks++;
    if ({ops_done, fifo_count, bus.out_valid} !== {8'd1, 3'd0, 1'b0}) begin
      n_fail++; $display("[TB] FAIL wrap_final: got done=%0d count=%0d valid=%b expected 1/0/0",
                         ops_done, fifo_count, bus.out_valid);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_fill();
    test_drain();
    test_sticky();
    test_midstream_reset();
    test_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end
endmodule

// File: doc/alu_issue_queue.md
# alu_issue_queue

Operand/op issue stage placed directly upstream of the 4-bit signed ALU `control_unit`. It buffers incoming ALU requests in a small FIFO and drives the ALU's `Ctrl1`, `Ctrl0`, `A` and `B` inputs from registers. It captures the ALU's `ResH`, `ResL`, `Zero`, `Overflow` and `Cout` outputs into a result register, presented downstream with a valid/ready handshake. It also keeps a sticky overflow flag and a completed-op counter.

## Interface
- `DEPTH`, 4: FIFO entries; power of two, ≥2.
- `clk`  in  1  clock, rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `in_valid`  in  1  request valid.
- `in_ready`  out  1  request accepted when `in_valid & in_ready` at a rising edge.
- `in_op`  in  2  ALU control code; bit1 goes to `Ctrl1`, bit0 to `Ctrl0`; not interpreted.
- `in_a`, `in_b`  in  4 each  signed operands.
- `Ctrl1`, `Ctrl0`  out  1 each  registered ALU control.
- `A`, `B`  out  4 each  registered ALU operands.
- `ResH`, `ResL`  in  4 each  ALU result, high and low nibble.
- `Zero`, `Overflow`, `Cout`  in  1 each  ALU flags.
- `out_valid`  out  1  result register holds a result.
- `out_ready`  in  1  downstream consumes when `out_valid & out_ready`.
- `out_res`  out  8  `{ResH,ResL}` as captured.
- `out_op`  out  2  op code that produced `out_res`.
- `out_zero`, `out_ov`, `out_cout`  out  1 each  captured flags.
- `clr_sticky`  in  1  synchronous clear of `sticky_ov`.
- `sticky_ov`  out  1  set by any captured result with `Overflow=1`.
- `fifo_count`  out  $clog2(DEPTH)+1  FIFO occupancy.
- `ops_done`  out  8  count of handshaken results; wraps.

## Operation
- Three storage stages: FIFO, operand stage (`opv` plus registered `Ctrl1`, `Ctrl0`, `A`, `B`), and result stage (`out_valid` plus the `out_*` registers).
- Stall signal: `stall = out_valid & ~out_ready`.
- Result stage:
  - If `~stall & opv`, capture `{ResH,ResL}`, flags and the op code, and set `out_valid=1`.
  - If `~stall & ~opv`, clear `out_valid`.
  - If `stall`, hold all result registers.
- Operand stage:
  - If `~stall`, load the FIFO head and pop it when `fifo_count>0`, setting `opv=1`.
  - Otherwise under `~stall`, `opv=0` and `A`, `B`, `Ctrl` hold their last values.
  - If `stall`, hold.
- FIFO push rule: `in_ready = (fifo_count < DEPTH)`, computed from registered count only.
  - When full, no push occurs even if a pop happens in the same cycle.
  - Push and pop in the same cycle when not full leaves the count unchanged.
  - No bypass: a request always spends at least one cycle in the FIFO.
  - Pointers wrap modulo DEPTH.
- Ordering: strict FIFO order end to end. No drops and no duplicates.
- `sticky_ov`:
  - Set when a result is captured with `Overflow=1`.
  - Cleared by `clr_sticky`.
  - A simultaneous set and clear leaves it 1.
- `ops_done`: increments by 1 on each output handshake; 255 wraps to 0.
- Reset (async, any time, including mid-operation):
  - FIFO flushed, `fifo_count=0`, `opv=0`, `out_valid=0`.
  - `Ctrl1=Ctrl0=0`, `A=B=0`.
  - `out_res=0`, `out_op=0`, all `out_*` flags 0, `sticky_ov=0`, `ops_done=0`.
  - `in_ready=1` after reset.
  - In-flight ops are discarded.

## Timing
- Latency, empty pipe, `out_ready=1`:
  - Request accepted at edge N.
  - Operands appear on `A`/`B`/`Ctrl` after edge N+1.
  - Result captured at edge N+2; `out_valid=1` after N+2.
- The ALU path is combinational and gets one full cycle between the operand and result registers.
- Throughput: one op per cycle with `out_ready` held high.
- Capacity with `out_ready=0`: DEPTH+2 requests before `in_ready` falls (result stage, operand stage, FIFO).
- `out_*` are stable while `out_valid & ~out_ready`.

## Test plan
- Reset mid-stream:
  - Stimulus: 3 ops queued, then `rst_n` pulsed low between edges.
  - Required response: immediately `out_valid=0`, `A=B=0`, `fifo_count=0`, `ops_done=0`. No result appears after release.
- Single op:
  - Stimulus: push `op=00`, `a=4'b1101`, `b=4'b0111` at edge 0, `out_ready=1`.
  - Required response: `A=1101`, `B=0111`, `Ctrl=00` after edge 1. `out_valid=1` after edge 2 with `out_res` equal to `{ResH,ResL}` driven by the ALU model. `ops_done=1` after edge 3.
- Fill:
  - Stimulus: `out_ready=0`, `in_valid=1` with 8 distinct requests.
  - Required response: exactly 6 accepted. `in_ready=0` with `fifo_count=4`.
- Drain:
  - Stimulus: from the filled state, set `out_ready=1` continuously.
  - Required response: 6 results on 6 consecutive cycles in push order; remaining 2 requests then accepted and completed; `ops_done=8`.
- Sticky:
  - Stimulus: op producing `Overflow=1` captured in the same cycle `clr_sticky=1`.
  - Required response: `sticky_ov=1`. A later `clr_sticky` alone gives `sticky_ov=0`.
- Wrap:
  - Stimulus: 257 results consumed.
  - Required response: `ops_done=1`. FIFO pointers wrap with order preserved.
